pwm_duty_scheduler: RTL and testbench

Controller that sits in front of the motor `pwm_generator` and owns its 4-bit `duty_cycle` input. Two requesters (A: line-follow logic, B: manoeuvre/turn logic) submit target duties through a valid/ready handshake, and fixed-priority arbitration selects one. The block ramps the applied duty one step at a time toward the accepted target, changing it only on PWM-period boundaries so that no period is truncated. An emergency-stop input overrides everything and forces the duty to zero immediately.

---
 rtl/pwm_ctrl_pkg.sv | 33 +++
 rtl/pwm_period_timer.sv | 46 ++++
 rtl/pwm_duty_scheduler.sv | 105 ++++++++++
 tb/tb_pwm_duty_scheduler.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_ctrl_pkg.sv
// pwm_ctrl_pkg
// Shared definitions for the PWM duty scheduler. It provides the scheduler
// state encoding, the duty width, the PWM period length and the owner codes.
// It also provides a helper that derives the ramp direction from a duty and
// target pair.
package pwm_ctrl_pkg;

    localparam int DUTY_W     = 4;
    localparam int PWM_PERIOD = 16;

    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2,
        ESTOP     = 2'd3
    } state_t;

    // The ramp state is fully determined by where the duty sits relative to
    // the target, so it is derived rather than tracked separately.
    function automatic state_t ramp_state(input logic [DUTY_W-1:0] duty,
                                          input logic [DUTY_W-1:0] target);
        if (duty < target)
            return RAMP_UP;
        else if (duty > target)
            return RAMP_DOWN;
        else
            return IDLE;
    endfunction

endpackage

// File: rtl/pwm_period_timer.sv
// pwm_period_timer
// This is the free-running PWM period counter, aligned with pwm_generator,
// plus the divider that turns period boundaries into ramp step ticks.
//   clk_3125KHz  in  : clock shared with pwm_generator
//   rst_n        in  : asynchronous active-low reset
//   period_start out : registered, high on the first cycle of each period
//   boundary     out : high on the last cycle of each period (cnt == 15)
//   step_tick    out : high on every RAMP_DIV-th boundary
module pwm_period_timer
    import pwm_ctrl_pkg::*;
#(
    parameter int RAMP_DIV = 1
) (
    input  logic clk_3125KHz,
    input  logic rst_n,
    output logic period_start,
    output logic boundary,
    output logic step_tick
);

    localparam int CNT_W = $clog2(PWM_PERIOD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PWM_PERIOD - 1);
    localparam logic [3:0]       DIV_LAST = 4'(RAMP_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic [3:0]       div;

    assign boundary  = (cnt == CNT_LAST);
    assign step_tick = boundary && (div == DIV_LAST);

    // period_start is registered by predicting the wrap one cycle early.
    // It comes out of reset high because cnt is 0 then.
    always_ff @(posedge clk_3125KHz or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            div          <= '0;
            period_start <= 1'b1;
        end else begin
            cnt          <= cnt + 1'b1;
            period_start <= boundary;
            if (boundary)
                div <= (div == DIV_LAST) ? 4'd0 : div + 4'd1;
        end
    end

endmodule

// File: rtl/pwm_duty_scheduler.sv
// pwm_duty_scheduler
// This block owns the duty_cycle input of pwm_generator. Two requesters submit
// target duties through valid/ready, and A has fixed priority over B. The
// applied duty ramps one step per step tick toward the target. Updates happen
// only on period boundaries, so no PWM period is truncated. estop forces the
// duty to zero on the next edge.
//   clk_3125KHz            in  : clock shared with pwm_generator
//   rst_n                  in  : asynchronous active-low reset
//   req_a_valid/duty/ready     : requester A handshake (priority)
//   req_b_valid/duty/ready     : requester B handshake
//   estop                  in  : level-sensitive emergency stop
//   duty_cycle             out : applied duty, 0..15 sixteenths
//   period_start           out : first cycle of each 16-cycle PWM period
//   busy                   out : duty_cycle differs from the target
//   owner                  out : source of the last accepted request (0=A, 1=B)
module pwm_duty_scheduler
    import pwm_ctrl_pkg::*;
#(
    parameter int RAMP_DIV = 1
) (
    input  logic              clk_3125KHz,
    input  logic              rst_n,
    input  logic              req_a_valid,
    input  logic [DUTY_W-1:0] req_a_duty,
    output logic              req_a_ready,
    input  logic              req_b_valid,
    input  logic [DUTY_W-1:0] req_b_duty,
    output logic              req_b_ready,
    input  logic              estop,
    output logic [DUTY_W-1:0] duty_cycle,
    output logic              period_start,
    output logic              busy,
    output logic              owner
);

    state_t            state, state_n;
    logic [DUTY_W-1:0] target, target_n, duty_n;
    logic              owner_n, busy_n;
    logic              boundary, step_tick;
    logic              accept_a, accept_b;

    pwm_period_timer #(.RAMP_DIV(RAMP_DIV)) u_timer (
        .clk_3125KHz (clk_3125KHz),
        .rst_n       (rst_n),
        .period_start(period_start),
        .boundary    (boundary),
        .step_tick   (step_tick)
    );

    // The readys are held low during reset so that nothing is accepted
    // into a register that is being cleared.
    assign req_a_ready = rst_n && !estop && (state != ESTOP);
    assign req_b_ready = req_a_ready && !req_a_valid;
    assign accept_a    = req_a_valid && req_a_ready;
    assign accept_b    = req_b_valid && req_b_ready;

    always_comb begin
        state_n  = state;
        duty_n   = duty_cycle;
        target_n = target;
        owner_n  = owner;
        if (estop) begin
            state_n  = ESTOP;
            duty_n   = '0;
            target_n = '0;
        end else if (state == ESTOP) begin
            state_n = IDLE;
        end else begin
            // The step moves toward the old target. A target accepted in the
            // same cycle only affects the direction from the next cycle.
            if (step_tick) begin
                if (state == RAMP_UP)
                    duty_n = duty_cycle + 1'b1;
                else if (state == RAMP_DOWN)
                    duty_n = duty_cycle - 1'b1;
            end
            if (accept_a) begin
                target_n = req_a_duty;
                owner_n  = OWNER_A;
            end else if (accept_b) begin
                target_n = req_b_duty;
                owner_n  = OWNER_B;
            end
            state_n = ramp_state(duty_n, target_n);
        end
        busy_n = (duty_n != target_n);
    end

    always_ff @(posedge clk_3125KHz or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            duty_cycle <= '0;
            target     <= '0;
            owner      <= OWNER_A;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            duty_cycle <= duty_n;
            target     <= target_n;
            owner      <= owner_n;
            busy       <= busy_n;
        end
    end

endmodule

// File: tb/tb_pwm_duty_scheduler.sv
// tb_pwm_duty_scheduler
// This bench drives two schedulers (RAMP_DIV=1 and RAMP_DIV=3) with the same
// stimulus. It compares them every cycle against a reference model. The model
// describes the ramp in terms of elapsed cycles: a boundary every 16 cycles,
// and a step on every RAMP_DIV-th boundary.
module tb_pwm_duty_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a_valid, b_valid, estop;
    logic [3:0] a_duty, b_duty;

    logic       rdy_a [2];
    logic       rdy_b [2];
    logic [3:0] duty  [2];
    logic       pstart[2];
    logic       busy  [2];
    logic       own   [2];

    int checks = 0;
    int errors = 0;

    int DIVS[2] = '{1, 3};
    int m_duty[2], m_target[2], m_owner[2];
    bit m_est[2];
    int m_cyc;

    always #5 clk = ~clk;

    pwm_duty_scheduler #(.RAMP_DIV(1)) dut1 (
        .clk_3125KHz(clk), .rst_n(rst_n),
        .req_a_valid(a_valid), .req_a_duty(a_duty), .req_a_ready(rdy_a[0]),
        .req_b_valid(b_valid), .req_b_duty(b_duty), .req_b_ready(rdy_b[0]),
        .estop(estop), .duty_cycle(duty[0]), .period_start(pstart[0]),
        .busy(busy[0]), .owner(own[0])
    );

    pwm_duty_scheduler #(.RAMP_DIV(3)) dut3 (
        .clk_3125KHz(clk), .rst_n(rst_n),
        .req_a_valid(a_valid), .req_a_duty(a_duty), .req_a_ready(rdy_a[1]),
        .req_b_valid(b_valid), .req_b_duty(b_duty), .req_b_ready(rdy_b[1]),
        .estop(estop), .duty_cycle(duty[1]), .period_start(pstart[1]),
        .busy(busy[1]), .owner(own[1])
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_duty[i] = 0; m_target[i] = 0; m_owner[i] = 0; m_est[i] = 1'b0;
        end
        m_cyc = 0;
    endtask

    // Check the readys, advance one clock, update the model, then check the
    // registered outputs on the falling edge.
    task automatic step();
        bit ra[2], rb[2];
        #1;
        for (int i = 0; i < 2; i++) begin
            ra[i] = !estop && !m_est[i];
            rb[i] = ra[i] && !a_valid;
            check($sformatf("rdy_a[%0d]", i), rdy_a[i], ra[i]);
            check($sformatf("rdy_b[%0d]", i), rdy_b[i], rb[i]);
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            bit tick;
            tick = ((m_cyc % 16) == 15) && ((((m_cyc / 16) + 1) % DIVS[i]) == 0);
            if (estop) begin
                m_duty[i] = 0; m_target[i] = 0; m_est[i] = 1'b1;
            end else if (m_est[i]) begin
                m_est[i] = 1'b0;
            end else begin
                if (tick) begin
                    if (m_target[i] > m_duty[i]) m_duty[i]++;
                    else if (m_target[i] < m_duty[i]) m_duty[i]--;
                end
                if (a_valid && ra[i]) begin
                    m_target[i] = a_duty; m_owner[i] = 0;
                end else if (b_valid && rb[i]) begin
                    m_target[i] = b_duty; m_owner[i] = 1;
                end
            end
        end
        m_cyc++;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("duty[%0d]", i), duty[i], m_duty[i]);
            check($sformatf("busy[%0d]", i), busy[i], m_duty[i] != m_target[i]);
            check($sformatf("owner[%0d]", i), own[i], m_owner[i]);
            check($sformatf("pstart[%0d]", i), pstart[i], (m_cyc % 16) == 0);
        end
    endtask

    // Asserts reset between clock edges and checks that the outputs clear
    // immediately. Reset is released on a falling edge.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("rst_duty", duty[i], 0);
            check("rst_pstart", pstart[i], 1);
            check("rst_busy", busy[i], 0);
            check("rst_owner", own[i], 0);
            check("rst_rdy_a", rdy_a[i], 0);
            check("rst_rdy_b", rdy_b[i], 0);
        end
        a_valid = 1'b0; b_valid = 1'b0; estop = 1'b0; a_duty = '0; b_duty = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic send_a(input int d);
        a_valid = 1'b1; a_duty = 4'(d);
        step();
        a_valid = 1'b0;
    endtask

    task automatic send_b(input int d);
        b_valid = 1'b1; b_duty = 4'(d);
        step();
        b_valid = 1'b0;
    endtask

    task automatic wait_duty(input int v, input int max_cycles);
        int k = 0;
        while (duty[0] != 4'(v) && k < max_cycles) begin
            step();
            k++;
        end
        check("reach_duty", duty[0], v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b1; a_valid = 1'b0; b_valid = 1'b0; estop = 1'b0;
        a_duty = '0; b_duty = '0;
        model_reset();
        @(negedge clk);
        do_reset();

        // RAMP_DIV=3: request 2 from 0, which should land exactly at cycle 96.
        send_a(2);
        repeat (94) step();
        check("div3_c95", duty[1], 1);
        step();
        check("div3_c96", duty[1], 2);

        // RAMP_DIV=1: A requests 5 from reset.
        do_reset();
        send_a(5);
        wait_duty(5, 200);
        check("a5_busy", busy[0], 0);
        check("a5_owner", own[0], 0);

        // Both requesters valid: only A is accepted.
        a_valid = 1'b1; a_duty = 4'd3; b_valid = 1'b1; b_duty = 4'd12;
        #1 check("both_rdy_b", rdy_b[0], 0);
        step();
        a_valid = 1'b0; b_valid = 1'b0;
        check("both_owner", own[0], 0);
        wait_duty(3, 100);

        // Reversal mid-ramp: toward 12, B retargets to 4 at duty 8.
        send_b(12);
        wait_duty(8, 200);
        send_b(4);
        check("rev_owner", own[0], 1);
        while (pstart[0] != 1'b1) step();
        check("rev_duty7", duty[0], 7);
        wait_duty(4, 100);

        // Emergency stop at duty 9 while ramping toward 15.
        send_a(15);
        wait_duty(9, 200);
        estop = 1'b1;
        step();
        check("estop_duty", duty[0], 0);
        #1 check("estop_rdy", rdy_a[0], 0);
        step(); step();
        estop = 1'b0;
        step();
        #1 check("estop_exit_rdy", rdy_a[0], 1);
        send_a(4);
        check("post_estop_busy", busy[0], 1);

        // Asynchronous reset mid-ramp at duty 6.
        send_a(10);
        wait_duty(6, 200);
        do_reset();
        step();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            a_valid = ($urandom_range(0, 9) == 0);
            b_valid = ($urandom_range(0, 7) == 0);
            a_duty  = 4'($urandom_range(0, 15));
            b_duty  = 4'($urandom_range(0, 15));
            if (estop) estop = ($urandom_range(0, 2) != 0);
            else       estop = ($urandom_range(0, 299) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
